// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, class and FSM state definitions shared by the ALU controller
package alu_pkg;

   // ALU_FUN opcode encoding
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_EQ   = 4'b1010;
   localparam logic [3:0] OP_GT   = 4'b1011;
   localparam logic [3:0] OP_LT   = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_SHL  = 4'b1110;
   localparam logic [3:0] OP_IDLE = 4'b1111;

   // Result class encoding; also the bit index of the matching ALU flag
   localparam logic [1:0] CLS_ARITH = 2'd0;
   localparam logic [1:0] CLS_LOGIC = 2'd1;
   localparam logic [1:0] CLS_CMP   = 2'd2;
   localparam logic [1:0] CLS_SHIFT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CAPT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Class of an opcode; the idle/illegal opcode reports arith
   function automatic logic [1:0] op_class(input logic [3:0] fun);
      if (fun <= OP_DIV)
         return CLS_ARITH;
      else if (fun <= OP_XNOR)
         return CLS_LOGIC;
      else if (fun <= OP_LT)
         return CLS_CMP;
      else if (fun <= OP_SHL)
         return CLS_SHIFT;
      else
         return CLS_ARITH;
   endfunction

   function automatic logic op_legal(input logic [3:0] fun);
      return fun != OP_IDLE;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational decode of a command into legality, div0 and expected class/flags
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        fun,
   input  logic [DATA_W-1:0] b,
   output logic              legal,
   output logic              div0,
   output logic [1:0]        cls,
   output logic [3:0]        flags
);

   // Flag vector order is {shift, cmp, logic, arith}, so the class value is the bit index
   always_comb begin
      legal = op_legal(fun);
      cls   = op_class(fun);
      div0  = (fun == OP_DIV) && (b == '0);
      flags = legal ? (4'b0001 << cls) : 4'b0000;
   end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - command/response controller driving the 16-bit registered ALU
module alu_cmd_ctrl
   import alu_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter int                CNT_W      = 8,
   parameter logic [DATA_W-1:0] DIV0_VALUE = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_fun,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_fun,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_arith_flag,
   input  logic              alu_logic_flag,
   input  logic              alu_cmp_flag,
   input  logic              alu_shift_flag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_class,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  op_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   state_t     state;
   state_t     state_nxt;

   logic       dec_legal;
   logic       dec_div0;
   logic [1:0] dec_cls;
   logic [3:0] dec_flags;

   logic       do_issue;
   logic       do_short;
   logic       do_capt;
   logic       do_hs;

   // Expected class/flags of the in-flight op, latched when it is issued to the ALU
   logic [1:0] exp_cls;
   logic [3:0] exp_flags;
   logic [3:0] alu_flags;

   assign alu_flags = {alu_shift_flag, alu_cmp_flag, alu_logic_flag, alu_arith_flag};
   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   alu_op_decode #(
      .DATA_W(DATA_W)
   ) u_decode (
      .fun  (cmd_fun),
      .b    (cmd_b),
      .legal(dec_legal),
      .div0 (dec_div0),
      .cls  (dec_cls),
      .flags(dec_flags)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state and per-cycle action strobes; illegal and div0 skip the ALU entirely
   always_comb begin
      state_nxt = state;
      do_issue  = 1'b0;
      do_short  = 1'b0;
      do_capt   = 1'b0;
      do_hs     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (!dec_legal || dec_div0) begin
                  do_short  = 1'b1;
                  state_nxt = ST_RESP;
               end else begin
                  do_issue  = 1'b1;
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: state_nxt = ST_CAPT;
         ST_CAPT: begin
            do_capt   = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               do_hs     = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ALU drive, response capture and expected-class bookkeeping
   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= OP_IDLE;
         rsp_data  <= '0;
         rsp_class <= CLS_ARITH;
         rsp_err   <= 1'b0;
         exp_cls   <= CLS_ARITH;
         exp_flags <= 4'b0000;
      end else begin
         if (do_issue) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_fun   <= cmd_fun;
            exp_cls   <= dec_cls;
            exp_flags <= dec_flags;
         end
         if (do_short) begin
            rsp_data  <= dec_div0 ? DIV0_VALUE : '0;
            rsp_class <= CLS_ARITH;
            rsp_err   <= 1'b1;
         end
         if (do_capt) begin
            rsp_data  <= alu_out;
            rsp_class <= exp_cls;
            rsp_err   <= (alu_flags != exp_flags);
            alu_fun   <= OP_IDLE;
         end
      end
   end

   // Saturating completion and error counters, stepped on the response handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_cnt  <= '0;
         err_cnt <= '0;
      end else if (do_hs) begin
         if (op_cnt != '1)
            op_cnt <= op_cnt + 1'b1;
         if (rsp_err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl with a registered ALU model
module tb_alu_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_fun;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_fun;
   logic [15:0] alu_out = 16'h0;
   logic        alu_arith_flag = 1'b0;
   logic        alu_logic_flag = 1'b0;
   logic        alu_cmp_flag = 1'b0;
   logic        alu_shift_flag = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_class;
   logic        rsp_err;
   logic [7:0]  op_cnt;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;
   int m_op = 0;
   int m_err = 0;
   bit force_cmp = 1'b0;
   bit saw_div0 = 1'b0;

   always #5 clk = ~clk;

   alu_cmd_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
      .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
      .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_class(rsp_class), .rsp_err(rsp_err),
      .op_cnt(op_cnt), .err_cnt(err_cnt)
   );

   function automatic int cls_of(input logic [3:0] f);
      if (f < 4) return 0;
      if (f < 10) return 1;
      if (f < 13) return 2;
      return 3;
   endfunction

   function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      case (f)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: begin p = a * b; return p[15:0]; end
         4'd3: return (b == 0) ? 16'h0 : a / b;
         4'd4: return a & b;
         4'd5: return a | b;
         4'd6: return ~(a & b);
         4'd7: return ~(a | b);
         4'd8: return a ^ b;
         4'd9: return ~(a ^ b);
         4'd10: return (a == b) ? 16'd1 : 16'd0;
         4'd11: return (a > b) ? 16'd2 : 16'd0;
         4'd12: return (a < b) ? 16'd3 : 16'd0;
         4'd13: return a >> 1;
         4'd14: return a << 1;
         default: return 16'h0;
      endcase
   endfunction

   // Registered ALU model; force_cmp corrupts the flag vector by raising the cmp flag
   always @(posedge clk) begin
      logic [3:0] fl;
      fl = (alu_fun == 4'hF) ? 4'b0000 : (4'b0001 << cls_of(alu_fun));
      if (force_cmp) fl[2] = 1'b1;
      alu_out <= alu_calc(alu_fun, alu_a, alu_b);
      {alu_shift_flag, alu_cmp_flag, alu_logic_flag, alu_arith_flag} <= fl;
   end

   // The ALU must never be handed a divide by zero
   always @(negedge clk) if (alu_fun == 4'h3 && alu_b == 16'h0) saw_div0 = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: what a response for (f,a,b) must look like and when it must appear
   task automatic ref_rsp(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] d, output int c, output bit e, output int lat);
      if (f == 4'hF) begin
         d = 16'h0; c = 0; e = 1; lat = 1;
      end else if (f == 4'h3 && b == 16'h0) begin
         d = 16'hFFFF; c = 0; e = 1; lat = 1;
      end else begin
         d = alu_calc(f, a, b); c = cls_of(f); e = 0; lat = 3;
      end
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // One command through to its handshake; starts and ends at a falling edge
   task automatic do_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit fault);
      logic [15:0] ed;
      int ec, el, n;
      bit ee;
      ref_rsp(f, a, b, ed, ec, ee, el);
      if (fault) ee = 1;
      chk("idle_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_fun = f; cmd_a = a; cmd_b = b; force_cmp = fault;
      @(posedge clk); @(negedge clk);
      cmd_valid = 0;
      n = 1;
      while (!rsp_valid && n < 10) begin
         chk("busy_ready", cmd_ready, 0);
         @(posedge clk); @(negedge clk);
         n++;
      end
      chk("latency", n, el);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_class", rsp_class, ec);
      chk("rsp_err", rsp_err, ee);
      chk("alu_fun_idle", alu_fun, 4'hF);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         chk("hold_valid", {cmd_ready, rsp_valid}, 2'b01);
         chk("hold_rsp", {rsp_err, rsp_class, rsp_data}, {ee, ec[1:0], ed});
      end
      rsp_ready = 1;
      @(posedge clk);
      m_op++;
      if (ee) m_err++;
      @(negedge clk);
      rsp_ready = 0; force_cmp = 0;
      chk("back_idle", {cmd_ready, rsp_valid}, 2'b10);
      chk("op_cnt", op_cnt, sat(m_op));
      chk("err_cnt", err_cnt, sat(m_err));
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst = 0; cmd_valid = 0; cmd_fun = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_valid", {cmd_ready, rsp_valid}, 2'b10);
      chk("rst_rsp", {rsp_err, rsp_class, rsp_data}, 19'h0);
      chk("rst_alu", {alu_a, alu_b, alu_fun}, {32'h0, 4'hF});
      chk("rst_cnt", {op_cnt, err_cnt}, 16'h0);
      rst = 1;
      @(negedge clk);

      do_op(4'h0, 16'h0003, 16'h0004, 0, 0);      // ADD
      do_op(4'hB, 16'h0009, 16'h0002, 5, 0);      // GT with backpressure
      do_op(4'h3, 16'h0010, 16'h0000, 0, 0);      // DIV by zero
      do_op(4'hF, 16'h1234, 16'h5678, 1, 0);      // illegal opcode
      do_op(4'h0, 16'h0001, 16'h0001, 0, 1);      // ADD with bad flags

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         do_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3), 0);
      end

      // Reset while the MUL is in EXEC
      cmd_valid = 1; cmd_fun = 4'h2; cmd_a = 16'h0100; cmd_b = 16'h0100;
      @(posedge clk); @(negedge clk);
      cmd_valid = 0;
      chk("exec_busy", cmd_ready, 0);
      rst = 0;
      @(posedge clk); @(negedge clk);
      rst = 1;
      m_op = 0; m_err = 0;
      chk("abort_state", {cmd_ready, rsp_valid}, 2'b10);
      chk("abort_alu_fun", alu_fun, 4'hF);
      chk("abort_cnt", {op_cnt, err_cnt}, 16'h0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end

      // Back-to-back XORs with the consumer always ready: one response per 4 cycles
      rsp_ready = 1; cmd_valid = 1; cmd_fun = 4'h8;
      for (int i = 0; i < 300; i++) begin
         chk("xor_ready", cmd_ready, 1);
         ra = 16'($urandom); rb = 16'($urandom);
         cmd_a = ra; cmd_b = rb;
         repeat (3) begin @(posedge clk); @(negedge clk); end
         chk("xor_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, ra ^ rb});
         @(posedge clk);
         m_op++;
         @(negedge clk);
      end
      cmd_valid = 0; rsp_ready = 0;
      chk("xor_op_cnt_sat", op_cnt, sat(m_op));
      chk("xor_err_cnt", err_cnt, sat(m_err));
      chk("no_div0_to_alu", saw_div0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
